// File: rtl/inv_mixcol.sv
// AES InvMixColumns engine: reads one 128-bit state word from SRAM at ADDR, transforms it, writes it back.
// Latency: enable sampled in IDLE -> sramRead in cycle 2, sramWrite in cycle 9, invmix_finished in cycle 10
//          (parallel build: 2 / 6 / 7).
// Backpressure: none; the SRAM is assumed to answer a read in the following cycle. Enable is ignored while busy.
//
// Ports:
//   clk, n_rst                      clock (rising edge), asynchronous active-low reset
//   invmix_enable                   start request, only looked at in IDLE
//   sramReadValue                   SRAM read data, valid the cycle after sramRead
//   sramWriteValue                  SRAM write data, driven from the working register in WRADDR/WRITE only
//   sramRead, sramWrite, sramAddr   SRAM strobes and address
//   sramDump/sramInit(+Num)         unused SRAM controls, tied low
//   invmix_finished                 one-cycle pulse in DONE
//
// Build option: define INVMIX_PARALLEL_EN to transform all four columns in a single COMPUTE cycle
// instead of one column per cycle. The written data is identical either way.

module inv_mixcol #(
  parameter logic [15:0] ADDR = 16'd32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         invmix_enable,
  input  logic [127:0] sramReadValue,
  output logic [127:0] sramWriteValue,
  output logic         invmix_finished,
  output logic         sramRead,
  output logic         sramWrite,
  output logic [15:0]  sramAddr,
  output logic         sramDump,
  output logic         sramInit,
  output logic [2:0]   sramDumpNum,
  output logic [2:0]   sramInitNum
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETADDR = 3'd1,
    READ    = 3'd2,
    WAITRD  = 3'd3,
    COMPUTE = 3'd4,
    WRADDR  = 3'd5,
    WRITE   = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [127:0] work;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One column of InvMixColumns. Byte 0 of the column sits in the top byte.
  // Each input byte is doubled three times; the 09/0b/0d/0e multiples are XOR
  // combinations of a, 2a, 4a, 8a.
  function automatic logic [31:0] inv_col(input logic [31:0] a);
    logic [7:0]  s   [4];
    logic [7:0]  m09 [4];
    logic [7:0]  m0b [4];
    logic [7:0]  m0d [4];
    logic [7:0]  m0e [4];
    logic [7:0]  x2;
    logic [7:0]  x4;
    logic [7:0]  x8;
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[31-8*i -: 8];
      x2     = xtime(s[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[i] = x8 ^ s[i];
      m0b[i] = x8 ^ x2 ^ s[i];
      m0d[i] = x8 ^ x4 ^ s[i];
      m0e[i] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      b[31-8*r -: 8] = m0e[r] ^ m0b[(r+1)%4] ^ m0d[(r+2)%4] ^ m09[(r+3)%4];
    end
    return b;
  endfunction

`ifndef INVMIX_PARALLEL_EN
  logic [1:0] col;
  logic [6:0] col_lsb;

  // Column c occupies bits [127-32c -: 32], i.e. its low bit is 32*(3-c).
  assign col_lsb = {~col, 5'b0_0000};
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = invmix_enable ? SETADDR : IDLE;
      SETADDR: next_state = READ;
      READ:    next_state = WAITRD;
      WAITRD:  next_state = COMPUTE;
`ifdef INVMIX_PARALLEL_EN
      COMPUTE: next_state = WRADDR;
`else
      COMPUTE: next_state = (col == 2'd3) ? WRADDR : COMPUTE;
`endif
      WRADDR:  next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from state only, so reset clears them immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    sramWriteValue  = '0;
    invmix_finished = 1'b0;
    sramRead        = 1'b0;
    sramWrite       = 1'b0;
    sramAddr        = '0;
    case (state)
      SETADDR: sramAddr = ADDR;
      READ: begin
        sramAddr = ADDR;
        sramRead = 1'b1;
      end
      WRADDR: begin
        sramAddr       = ADDR;
        sramWriteValue = work;
      end
      WRITE: begin
        sramAddr       = ADDR;
        sramWrite      = 1'b1;
        sramWriteValue = work;
      end
      DONE:    invmix_finished = 1'b1;
      default: ;
    endcase
  end

  assign sramDump    = 1'b0;
  assign sramInit    = 1'b0;
  assign sramDumpNum = 3'd0;
  assign sramInitNum = 3'd0;

  // ---------------------------------------------------------------------------
  // Working register and column counter
  // ---------------------------------------------------------------------------
`ifdef INVMIX_PARALLEL_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      work <= '0;
    end else begin
      case (state)
        WAITRD:  work <= sramReadValue;
        COMPUTE: work <= {inv_col(work[127:96]), inv_col(work[95:64]),
                          inv_col(work[63:32]),  inv_col(work[31:0])};
        default: ;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      work <= '0;
      col  <= 2'd0;
    end else begin
      case (state)
        WAITRD: begin
          work <= sramReadValue;
          col  <= 2'd0;
        end
        COMPUTE: begin
          // Wraps back to 0 after column 3, ready for the next operation.
          work[col_lsb +: 32] <= inv_col(work[col_lsb +: 32]);
          col                 <= col + 2'd1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_inv_mixcol.sv
module tb_inv_mixcol;

  localparam logic [15:0] ADDR = 16'd32;
`ifdef INVMIX_PARALLEL_EN
  localparam int RD_CYC = 2, WR_CYC = 6, FIN_CYC = 7;
`else
  localparam int RD_CYC = 2, WR_CYC = 9, FIN_CYC = 10;
`endif
  localparam int PERIOD = FIN_CYC + 1;

  logic         clk;
  logic         n_rst;
  logic         invmix_enable;
  logic [127:0] sramReadValue;
  logic [127:0] sramWriteValue;
  logic         invmix_finished;
  logic         sramRead;
  logic         sramWrite;
  logic [15:0]  sramAddr;
  logic         sramDump;
  logic         sramInit;
  logic [2:0]   sramDumpNum;
  logic [2:0]   sramInitNum;

  inv_mixcol #(.ADDR(ADDR)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .invmix_enable  (invmix_enable),
    .sramReadValue  (sramReadValue),
    .sramWriteValue (sramWriteValue),
    .invmix_finished(invmix_finished),
    .sramRead       (sramRead),
    .sramWrite      (sramWrite),
    .sramAddr       (sramAddr),
    .sramDump       (sramDump),
    .sramInit       (sramInit),
    .sramDumpNum    (sramDumpNum),
    .sramInitNum    (sramInitNum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [127:0] mem;
  logic         rd_pend;
  int           cyc;
  int           rd_cnt, wr_cnt, fin_cnt;
  int           rd_at, wr_at, fin_at;
  logic [127:0] wr_dat;
  logic [15:0]  rd_addr, wr_addr;
  int           fin_list[$];

  // ---------------- reference model ----------------
  // Schoolbook carry-less product followed by polynomial long division by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix product per column: b_r = sum_k row[k] * a_(r+k).
  function automatic logic [127:0] mix(input logic [127:0] w, input logic [31:0] row);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(row[31-8*k -: 8], w[127-32*c-8*((r+k)%4) -: 8]);
        o[127-32*c-8*r -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] inv_ref(input logic [127:0] w);
    return mix(w, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] fwd_ref(input logic [127:0] w);
    return mix(w, 32'h02030101);
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {5'd0, sramWriteValue, invmix_finished, sramRead, sramWrite, sramAddr,
            sramDump, sramInit, sramDumpNum, sramInitNum};
  endfunction

  task automatic clear_stats();
    cyc = 0; rd_cnt = 0; wr_cnt = 0; fin_cnt = 0;
    rd_at = -1; wr_at = -1; fin_at = -1;
    wr_dat = '0; rd_addr = '0; wr_addr = '0;
    fin_list.delete();
  endtask

  // Advance one cycle, sample #1 after the edge, and play the SRAM:
  // read data is only valid in the cycle after a sramRead, junk otherwise.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pend) sramReadValue = mem;
    else         sramReadValue = {$urandom, $urandom, $urandom, $urandom};
    rd_pend = sramRead;
    if (sramRead) begin
      rd_cnt++; rd_at = cyc; rd_addr = sramAddr;
    end
    if (sramWrite) begin
      wr_cnt++; wr_at = cyc; wr_dat = sramWriteValue; wr_addr = sramAddr;
    end
    if (invmix_finished) begin
      fin_cnt++; fin_at = cyc; fin_list.push_back(cyc);
    end
  endtask

  // One operation started from IDLE with a single-cycle enable pulse.
  task automatic run_op(input logic [127:0] word, input string tag, input bit timing);
    mem = word;
    clear_stats();
    invmix_enable = 1'b1;
    tick();
    invmix_enable = 1'b0;
    repeat (FIN_CYC + 4) tick();
    check({tag, "_wr_cnt"}, 160'(wr_cnt), 160'd1);
    check({tag, "_data"}, 160'(wr_dat), 160'(inv_ref(word)));
    check({tag, "_roundtrip"}, 160'(fwd_ref(wr_dat)), 160'(word));
    if (timing) begin
      check({tag, "_rd_cnt"}, 160'(rd_cnt), 160'd1);
      check({tag, "_fin_cnt"}, 160'(fin_cnt), 160'd1);
      check({tag, "_rd_cyc"}, 160'(rd_at), 160'(RD_CYC));
      check({tag, "_wr_cyc"}, 160'(wr_at), 160'(WR_CYC));
      check({tag, "_fin_cyc"}, 160'(fin_at), 160'(FIN_CYC));
      check({tag, "_rd_addr"}, 160'(rd_addr), 160'(ADDR));
      check({tag, "_wr_addr"}, 160'(wr_addr), 160'(ADDR));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    int           n_ops;

    n_rst = 1'b0;
    invmix_enable = 1'b0;
    sramReadValue = '0;
    rd_pend = 1'b0;
    mem = '0;
    clear_stats();

    // Reset state, before and after clock edges
    #2;
    check("reset_outs_async", all_outs(), 160'd0);
    repeat (2) tick();
    check("reset_outs_clocked", all_outs(), 160'd0);
    n_rst = 1'b1;
    tick();
    check("idle_outs", all_outs(), 160'd0);

    // FIPS-197 column: 04 66 81 e5 is MixColumns(d4 bf 5d 30)
    run_op({4{32'h046681e5}}, "fips", 1'b1);
    check("fips_const", 160'(wr_dat), 160'({4{32'hd4bf5d30}}));

    // Byte order as listed in the requirements text, checked through the model
    run_op({4{32'h048166e5}}, "vec048166e5", 1'b0);

    run_op(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "vec2", 1'b1);
    check("vec2_const", 160'(wr_dat), 160'(128'hdb135345_f20a225c_01010101_c6c6c6c6));

    // Corners: all zero, all ones
    run_op('0, "zero", 1'b0);
    run_op({128{1'b1}}, "ones", 1'b0);

    // Random words
    for (int i = 0; i < 6; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      run_op(w, $sformatf("rand%0d", i), 1'b1);
    end

    // Enable toggled while busy must have no effect
    mem = {$urandom, $urandom, $urandom, $urandom};
    clear_stats();
    invmix_enable = 1'b1;
    tick();
    repeat (FIN_CYC + 6) begin
      invmix_enable = (cyc < FIN_CYC) && (cyc % 2 == 1);
      tick();
    end
    invmix_enable = 1'b0;
    check("toggle_rd_cnt", 160'(rd_cnt), 160'd1);
    check("toggle_wr_cnt", 160'(wr_cnt), 160'd1);
    check("toggle_fin_cnt", 160'(fin_cnt), 160'd1);
    check("toggle_fin_cyc", 160'(fin_at), 160'(FIN_CYC));
    check("toggle_data", 160'(wr_dat), 160'(inv_ref(mem)));

    // Enable held high for 30 cycles: back-to-back with one IDLE cycle between
    mem = {$urandom, $urandom, $urandom, $urandom};
    clear_stats();
    invmix_enable = 1'b1;
    while (cyc < 30) tick();
    invmix_enable = 1'b0;
    while (cyc < 30 + PERIOD + 3) tick();
    n_ops = (30 + PERIOD - 1) / PERIOD;
    check("b2b_fin_cnt", 160'(fin_cnt), 160'(n_ops));
    check("b2b_rd_cnt", 160'(rd_cnt), 160'(n_ops));
    check("b2b_wr_cnt", 160'(wr_cnt), 160'(n_ops));
    for (int i = 0; i < n_ops && i < fin_list.size(); i++)
      check($sformatf("b2b_fin_cyc%0d", i), 160'(fin_list[i]), 160'(FIN_CYC + i * PERIOD));
    check("b2b_data", 160'(wr_dat), 160'(inv_ref(mem)));

    // Reset pulsed during COMPUTE aborts the operation
    mem = {$urandom, $urandom, $urandom, $urandom};
    clear_stats();
    invmix_enable = 1'b1;
    tick();
    invmix_enable = 1'b0;
    repeat (4) tick();
    n_rst = 1'b0;
    #1;
    check("abort_outs_zero", all_outs(), 160'd0);
    tick();
    check("abort_outs_held", all_outs(), 160'd0);
    n_rst = 1'b1;
    repeat (15) tick();
    check("abort_wr_cnt", 160'(wr_cnt), 160'd0);
    check("abort_fin_cnt", 160'(fin_cnt), 160'd0);
    check("abort_rd_cnt", 160'(rd_cnt), 160'd1);
    check("abort_idle_outs", all_outs(), 160'd0);
    run_op({$urandom, $urandom, $urandom, $urandom}, "after_abort", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
